ic_line_unit: RTL and testbench
===============================

IC_LINE_UNIT -- requirements
Module: ic_line_unit

Interface
REQ-001 Parameter IWIDTH, default 14, log2 of instruction RAM depth in 32-bit words; line = 4 words = 128 bits; line index width IWIDTH-2.
REQ-002 Single clock domain; reset is asynchronous and active-low.
REQ-003 Ports, clock and reset first:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pc_if  in  [31:2]  current fetch PC.
- pc_start  in  1  CPU start pulse.
- i_read_sel  in  1  monitor owns instruction RAM; suppresses lookup.
- ic_flush  in  1  invalidate-all request, single-cycle pulse.
- ic_rreq_m  out  1  line read request to DRAM bus.
- ic_radr_m  out  [31:4]  line address of the request.
- ic_rreq_ack  in  1  bus accepted request.
- ic_rdat_m_valid  in  1  128-bit line returned (data goes directly to the instruction RAM).
- ic_ram_wadr_all  out  [IWIDTH-3:0]  instruction RAM line write index.
- ic_stall  out  1  fetch stall.
- ic_stall_dly  out  1  ic_stall delayed 1 cycle.
- ic_stall_fin  out  1  fill-complete pulse.
- ic_stall_fin2  out  1  ic_stall_fin delayed 1 cycle.

Function
REQ-004 Direct-mapped tag store, 2^(IWIDTH-2) entries, each valid bit + tag pc[31:IWIDTH+2]; index pc[IWIDTH+1:4]; combinational read.
REQ-005 hit = valid[idx] & (tag[idx] == pc_if tag field); lookup_miss = (state==IDLE) & ~hit & ~i_read_sel & ~pc_start & ~flush_pend.
REQ-006 States: IDLE, REQ, WAIT, FIN.
REQ-007 IDLE: lookup_miss -> capture miss_adr <= pc_if[31:4], go to REQ; otherwise stay.
REQ-008 REQ: ic_rreq_m=1, ic_radr_m=miss_adr; ic_rreq_ack=1 -> WAIT. Request held stable until acked.
REQ-009 WAIT: ic_rdat_m_valid=1 -> write valid[miss idx]=1, tag[miss idx]=miss tag at that edge; go to FIN.
REQ-010 FIN: exactly one cycle, then IDLE.
REQ-011 ic_rdat_m_valid outside WAIT is ignored; tag store unchanged.
REQ-012 ic_ram_wadr_all = miss_adr[IWIDTH+1:4], stable from REQ entry through FIN.
REQ-013 ic_stall = lookup_miss | (state != IDLE); combinational, so a miss stalls in its detection cycle.
REQ-014 ic_stall_fin = (state==FIN); ic_stall_dly and ic_stall_fin2 are registered 1-cycle delays.
REQ-015 Minimum miss latency, miss cycle to first IDLE cycle with hit: 4 cycles when ack arrives in first REQ cycle and data in first WAIT cycle.
REQ-016 A started fill is never cancelled; a PC redirect during a fill waits until IDLE and is then looked up normally.
REQ-017 ic_flush in IDLE clears all valid bits at the next edge.
REQ-018 ic_flush in any other state sets flush_pend; the clear is applied on the first IDLE cycle (including the line just filled). flush_pend blocks new misses while set, then clears.
REQ-019 Simultaneous ic_flush and lookup_miss in IDLE: flush takes precedence and no request is issued that cycle; the miss is re-detected the next cycle.
REQ-020 ic_rreq_ack and ic_rdat_m_valid in the same cycle while in REQ: only the ack is taken; data is expected in WAIT.

Reset
REQ-021 Reset values:
- state=IDLE; all valid bits=0; flush_pend=0; miss_adr=0.
- ic_rreq_m=0, ic_stall_dly=0, ic_stall_fin=0, ic_stall_fin2=0.
- ic_stall follows REQ-013.
REQ-022 Tag fields need no reset. Reset mid-fill returns to IDLE immediately; a late ic_rdat_m_valid after reset is ignored.

Verification
REQ-023 Cold miss: IWIDTH=14, pc_if=0x0000_1000>>2, pc_start=0, ack and valid each 1 cycle after entry -> ic_stall=1 in miss cycle; ic_radr_m=0x0000100; ic_ram_wadr_all=0x100; one ic_stall_fin pulse; next cycle hit with ic_stall=0; ic_stall_fin2 one cycle after ic_stall_fin.
REQ-024 Tag conflict: fill 0x0000_1000, then fetch 0x0001_1000 -> miss, same index 0x100, tag 0x0001 replaces 0x0000; refetch of 0x0000_1000 misses again.
REQ-025 Slow bus: ack delayed 5 cycles, valid delayed 7 more -> ic_rreq_m and ic_radr_m held for 5 cycles; ic_stall continuously high until FIN; exactly one fin pulse.
REQ-026 Flush during WAIT -> fill completes; first IDLE cycle clears all valid bits; next fetch of the same PC misses.
REQ-027 i_read_sel=1 with cold cache -> no request, ic_stall=0.
REQ-028 rst_n asserted in WAIT, then released, then stray ic_rdat_m_valid -> state=IDLE, no valid bit set, no ic_stall_fin pulse.

Source files
------------

// File: rtl/ic_line_unit_if.sv
// Line-fill handshake between the instruction cache line unit (master) and the DRAM bus (slave).
interface ic_line_unit_if;
  logic        ic_rreq_m;
  logic [31:4] ic_radr_m;
  logic        ic_rreq_ack;
  logic        ic_rdat_m_valid;

  modport master (
    output ic_rreq_m,
    output ic_radr_m,
    input  ic_rreq_ack,
    input  ic_rdat_m_valid
  );

  modport slave (
    input  ic_rreq_m,
    input  ic_radr_m,
    output ic_rreq_ack,
    output ic_rdat_m_valid
  );
endinterface

// File: rtl/ic_line_unit.sv
// Direct-mapped instruction cache tag store and line-fill controller.
// On a fetch miss it requests the 128-bit line from DRAM and stalls fetch until the fill completes.
module ic_line_unit #(
  parameter int IWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:2]       pc_if,
  input  logic              pc_start,
  input  logic              i_read_sel,
  input  logic              ic_flush,
  ic_line_unit_if.master    bus,
  output logic [IWIDTH-3:0] ic_ram_wadr_all,
  output logic              ic_stall,
  output logic              ic_stall_dly,
  output logic              ic_stall_fin,
  output logic              ic_stall_fin2
);

  localparam int LINES = 1 << (IWIDTH - 2);
  localparam int TAGW  = 30 - IWIDTH;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

  state_t            r_state;
  logic [LINES-1:0]  r_valid;
  logic [TAGW-1:0]   r_tag [LINES];
  logic [31:4]       r_miss_adr;
  logic              r_flush_pend;
  logic              r_rreq;
  logic              r_fin;
  logic              r_stall_dly;
  logic              r_fin2;

  logic [IWIDTH-3:0] w_idx;
  logic [IWIDTH-3:0] w_miss_idx;
  logic [TAGW-1:0]   w_tag;
  logic [TAGW-1:0]   w_miss_tag;
  logic              w_hit;
  logic              w_lookup_miss;
  logic              w_fill_done;
  logic              w_unused;

  assign w_idx      = pc_if[IWIDTH+1:4];
  assign w_tag      = pc_if[31:IWIDTH+2];
  assign w_miss_idx = r_miss_adr[IWIDTH+1:4];
  assign w_miss_tag = r_miss_adr[31:IWIDTH+2];
  assign w_unused   = ^pc_if[3:2];

  assign w_hit         = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_lookup_miss = (r_state == IDLE) & ~w_hit & ~i_read_sel & ~pc_start & ~r_flush_pend;
  assign w_fill_done   = (r_state == WAIT) & bus.ic_rdat_m_valid;

  // Tags carry no reset; a stale tag is harmless while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_miss_idx] <= w_miss_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_miss_adr   <= '0;
      r_flush_pend <= 1'b0;
      r_rreq       <= 1'b0;
      r_fin        <= 1'b0;
      r_stall_dly  <= 1'b0;
      r_fin2       <= 1'b0;
    end else begin
      r_stall_dly <= ic_stall;
      r_fin2      <= r_fin;
      unique case (r_state)
        IDLE: begin
          // A pending or fresh flush wins over a miss; the miss is re-detected next cycle.
          if (ic_flush || r_flush_pend) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else if (w_lookup_miss) begin
            r_miss_adr <= pc_if[31:4];
            r_rreq     <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (ic_flush) r_flush_pend <= 1'b1;
          if (bus.ic_rreq_ack) begin
            r_rreq  <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (ic_flush) r_flush_pend <= 1'b1;
          if (bus.ic_rdat_m_valid) begin
            r_valid[w_miss_idx] <= 1'b1;
            r_fin               <= 1'b1;
            r_state             <= FIN;
          end
        end
        FIN: begin
          if (ic_flush) r_flush_pend <= 1'b1;
          r_fin   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ic_rreq_m   = r_rreq;
  assign bus.ic_radr_m   = r_miss_adr;
  assign ic_ram_wadr_all = w_miss_idx;
  assign ic_stall        = w_lookup_miss | (r_state != IDLE);
  assign ic_stall_dly    = r_stall_dly;
  assign ic_stall_fin    = r_fin;
  assign ic_stall_fin2   = r_fin2;

endmodule

// File: tb/tb_ic_line_unit.sv
// Self-checking bench for ic_line_unit: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a transaction-level cache model.
module tb_ic_line_unit;
  localparam int IWIDTH = 14;
  localparam int LINES  = 1 << (IWIDTH - 2);

  logic              clk;
  logic              rst_n;
  logic [31:2]       pc_if;
  logic              pc_start;
  logic              i_read_sel;
  logic              ic_flush;
  logic [IWIDTH-3:0] ic_ram_wadr_all;
  logic              ic_stall;
  logic              ic_stall_dly;
  logic              ic_stall_fin;
  logic              ic_stall_fin2;

  ic_line_unit_if bus ();

  ic_line_unit #(.IWIDTH(IWIDTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_if           (pc_if),
    .pc_start        (pc_start),
    .i_read_sel      (i_read_sel),
    .ic_flush        (ic_flush),
    .bus             (bus),
    .ic_ram_wadr_all (ic_ram_wadr_all),
    .ic_stall        (ic_stall),
    .ic_stall_dly    (ic_stall_dly),
    .ic_stall_fin    (ic_stall_fin),
    .ic_stall_fin2   (ic_stall_fin2)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what the cache holds plus where the outstanding fill stands.
  bit          mValid [LINES];
  int unsigned mTag   [LINES];
  bit          mActive, mAcked, mFilled, mFlushPend, mPrevStall, mPrevFin;
  logic [31:4] mLine;
  bit          eStall, eRreq, eFin, eMiss;

  typedef struct {
    logic [31:0] pcByte;
    bit          ack;
    bit          dval;
    bit          eStall;
    bit          eRreq;
    logic [27:0] eRadr;
    logic [11:0] eWadr;
    bit          eFin;
    bit          eFin2;
  } vec_t;

  vec_t vecs [15];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pcByte, input bit rs, input bit ps,
                               input bit fl, input bit ack, input bit dv);
    pc_if               = pcByte[31:2];
    i_read_sel          = rs;
    pc_start            = ps;
    ic_flush            = fl;
    bus.ic_rreq_ack     = ack;
    bus.ic_rdat_m_valid = dv;
  endtask

  task automatic modelReset();
    foreach (mValid[i]) mValid[i] = 1'b0;
    mActive    = 1'b0;
    mAcked     = 1'b0;
    mFilled    = 1'b0;
    mFlushPend = 1'b0;
    mPrevStall = 1'b0;
    mPrevFin   = 1'b0;
    mLine      = '0;
  endtask

  task automatic predict();
    int          idx;
    int unsigned tag;
    bit          hit;
    idx    = int'(pc_if[IWIDTH+1:4]);
    tag    = 32'(pc_if[31:IWIDTH+2]);
    hit    = mValid[idx] && (mTag[idx] == tag);
    eMiss  = !mActive && !hit && !i_read_sel && !pc_start && !mFlushPend;
    eStall = eMiss || mActive;
    eRreq  = mActive && !mAcked;
    eFin   = mActive && mFilled;
  endtask

  task automatic settleAndCheck();
    #3;
    predict();
    checkOutput("ic_stall", 32'(ic_stall), 32'(eStall));
    checkOutput("ic_rreq_m", 32'(bus.ic_rreq_m), 32'(eRreq));
    checkOutput("ic_stall_fin", 32'(ic_stall_fin), 32'(eFin));
    checkOutput("ic_stall_dly", 32'(ic_stall_dly), 32'(mPrevStall));
    checkOutput("ic_stall_fin2", 32'(ic_stall_fin2), 32'(mPrevFin));
    if (eRreq) checkOutput("ic_radr_m", 32'(bus.ic_radr_m), 32'(mLine));
    if (mActive) checkOutput("ic_ram_wadr_all", 32'(ic_ram_wadr_all), 32'(mLine[IWIDTH+1:4]));
  endtask

  task automatic advance();
    @(posedge clk);
    if (!mActive) begin
      if (ic_flush || mFlushPend) begin
        foreach (mValid[i]) mValid[i] = 1'b0;
        mFlushPend = 1'b0;
      end else if (eMiss) begin
        mActive = 1'b1;
        mAcked  = 1'b0;
        mFilled = 1'b0;
        mLine   = pc_if[31:4];
      end
    end else begin
      if (ic_flush) mFlushPend = 1'b1;
      if (mFilled) begin
        mActive = 1'b0;
      end else if (!mAcked) begin
        if (bus.ic_rreq_ack) mAcked = 1'b1;
      end else if (bus.ic_rdat_m_valid) begin
        mValid[int'(mLine[IWIDTH+1:4])] = 1'b1;
        mTag[int'(mLine[IWIDTH+1:4])]   = 32'(mLine[31:IWIDTH+2]);
        mFilled = 1'b1;
      end
    end
    mPrevStall = eStall;
    mPrevFin   = eFin;
    #1;
  endtask

  task automatic tick();
    settleAndCheck();
    advance();
  endtask

  // Asserts reset asynchronously, checks the reset values, then releases just after an edge.
  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    #2;
    predict();
    checkOutput("reset ic_rreq_m", 32'(bus.ic_rreq_m), 32'd0);
    checkOutput("reset ic_stall_fin", 32'(ic_stall_fin), 32'd0);
    checkOutput("reset ic_stall_fin2", 32'(ic_stall_fin2), 32'd0);
    checkOutput("reset ic_stall_dly", 32'(ic_stall_dly), 32'd0);
    checkOutput("reset ic_ram_wadr_all", 32'(ic_ram_wadr_all), 32'd0);
    checkOutput("reset ic_stall", 32'(ic_stall), 32'(eStall));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int          finCount;
    logic [11:0] idxTab [4];
    logic [31:0] pcByte;

    idxTab[0] = 12'h100;
    idxTab[1] = 12'h101;
    idxTab[2] = 12'h200;
    idxTab[3] = 12'h7ff;

    // Cold miss, tag conflict replacement, and refetch of the evicted line.
    vecs[0]  = '{32'h0000_1000, 0, 0, 1, 0, 28'h0,    12'h000, 0, 0};
    vecs[1]  = '{32'h0000_1000, 1, 0, 1, 1, 28'h100,  12'h100, 0, 0};
    vecs[2]  = '{32'h0000_1000, 0, 1, 1, 0, 28'h0,    12'h100, 0, 0};
    vecs[3]  = '{32'h0000_1000, 0, 0, 1, 0, 28'h0,    12'h100, 1, 0};
    vecs[4]  = '{32'h0000_1000, 0, 0, 0, 0, 28'h0,    12'h100, 0, 1};
    vecs[5]  = '{32'h0001_1000, 0, 0, 1, 0, 28'h0,    12'h100, 0, 0};
    vecs[6]  = '{32'h0001_1000, 1, 0, 1, 1, 28'h1100, 12'h100, 0, 0};
    vecs[7]  = '{32'h0001_1000, 0, 1, 1, 0, 28'h0,    12'h100, 0, 0};
    vecs[8]  = '{32'h0001_1000, 0, 0, 1, 0, 28'h0,    12'h100, 1, 0};
    vecs[9]  = '{32'h0001_1000, 0, 0, 0, 0, 28'h0,    12'h100, 0, 1};
    vecs[10] = '{32'h0000_1000, 0, 0, 1, 0, 28'h0,    12'h100, 0, 0};
    vecs[11] = '{32'h0000_1000, 1, 0, 1, 1, 28'h100,  12'h100, 0, 0};
    vecs[12] = '{32'h0000_1000, 0, 1, 1, 0, 28'h0,    12'h100, 0, 0};
    vecs[13] = '{32'h0000_1000, 0, 0, 1, 0, 28'h0,    12'h100, 1, 0};
    vecs[14] = '{32'h0000_1000, 0, 0, 0, 0, 28'h0,    12'h100, 0, 1};

    rst_n = 1'b1;
    applyStimulus(32'h0000_1000, 0, 0, 0, 0, 0);
    #1;
    doReset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pcByte, 0, 0, 0, vecs[i].ack, vecs[i].dval);
      settleAndCheck();
      checkOutput($sformatf("vec%0d ic_stall", i), 32'(ic_stall), 32'(vecs[i].eStall));
      checkOutput($sformatf("vec%0d ic_rreq_m", i), 32'(bus.ic_rreq_m), 32'(vecs[i].eRreq));
      if (vecs[i].eRreq)
        checkOutput($sformatf("vec%0d ic_radr_m", i), 32'(bus.ic_radr_m), 32'(vecs[i].eRadr));
      checkOutput($sformatf("vec%0d ic_ram_wadr_all", i), 32'(ic_ram_wadr_all), 32'(vecs[i].eWadr));
      checkOutput($sformatf("vec%0d ic_stall_fin", i), 32'(ic_stall_fin), 32'(vecs[i].eFin));
      checkOutput($sformatf("vec%0d ic_stall_fin2", i), 32'(ic_stall_fin2), 32'(vecs[i].eFin2));
      advance();
    end

    // Slow bus: request held 5 cycles (stray data while requesting is ignored), data 7 cycles later.
    applyStimulus(32'h0000_2000, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h0000_2000, 0, 0, 0, i == 4, i >= 3);
      settleAndCheck();
      checkOutput("slow rreq held", 32'(bus.ic_rreq_m), 32'd1);
      checkOutput("slow radr held", 32'(bus.ic_radr_m), 32'h200);
      advance();
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(32'h0000_2000, 0, 0, 0, 0, i == 6);
      settleAndCheck();
      checkOutput("slow stall in wait", 32'(ic_stall), 32'd1);
      checkOutput("slow rreq dropped", 32'(bus.ic_rreq_m), 32'd0);
      advance();
    end
    finCount = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h0000_2000, 0, 0, 0, 0, 0);
      settleAndCheck();
      finCount += int'(ic_stall_fin);
      advance();
    end
    checkOutput("slow fin pulse count", 32'(finCount), 32'd1);

    // Flush during the data wait: fill completes, then everything is invalidated.
    applyStimulus(32'h0000_3000, 0, 0, 0, 1, 0);
    tick();
    tick();
    applyStimulus(32'h0000_3000, 0, 0, 1, 0, 0);
    tick();
    applyStimulus(32'h0000_3000, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(32'h0000_3000, 0, 0, 0, 0, 0);
    settleAndCheck();
    checkOutput("flush fill fin", 32'(ic_stall_fin), 32'd1);
    advance();
    settleAndCheck();
    checkOutput("flush first idle no stall", 32'(ic_stall), 32'd0);
    advance();
    settleAndCheck();
    checkOutput("flush refetch misses", 32'(ic_stall), 32'd1);
    advance();
    applyStimulus(32'h0000_3000, 0, 0, 0, 1, 1);
    repeat (4) tick();
    applyStimulus(32'h0000_2000, 0, 0, 0, 0, 0);
    settleAndCheck();
    checkOutput("flush other line misses", 32'(ic_stall), 32'd1);
    advance();
    applyStimulus(32'h0000_2000, 0, 0, 0, 1, 1);
    repeat (4) tick();

    // Monitor owns the RAM on a cold cache: no lookup, no stall.
    applyStimulus(32'h0000_4000, 1, 0, 0, 0, 0);
    doReset();
    for (int i = 0; i < 3; i++) begin
      settleAndCheck();
      checkOutput("read_sel no stall", 32'(ic_stall), 32'd0);
      checkOutput("read_sel no request", 32'(bus.ic_rreq_m), 32'd0);
      advance();
    end

    // Reset in the data wait, then a late data beat must not fill anything.
    applyStimulus(32'h0000_5000, 0, 0, 0, 1, 0);
    tick();
    tick();
    applyStimulus(32'h0000_5000, 0, 0, 0, 0, 0);
    tick();
    doReset();
    applyStimulus(32'h0000_5000, 1, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      settleAndCheck();
      checkOutput("post-reset idle no stall", 32'(ic_stall), 32'd0);
      checkOutput("post-reset no fin", 32'(ic_stall_fin), 32'd0);
      advance();
    end
    applyStimulus(32'h0000_5000, 0, 0, 0, 0, 0);
    settleAndCheck();
    checkOutput("post-reset line not valid", 32'(ic_stall), 32'd1);
    advance();
    applyStimulus(32'h0000_5000, 0, 0, 0, 1, 1);
    repeat (4) tick();

    // Randomized traffic over a few colliding lines.
    for (int n = 0; n < 3000; n++) begin
      pcByte = (32'($urandom_range(0, 2)) << 16) | (32'(idxTab[$urandom_range(0, 3)]) << 4)
             | (32'($urandom_range(0, 3)) << 2);
      applyStimulus(pcByte, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 4);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
